tetris_input_gen: RTL and testbench

Command source for the tetris piece controller. Turns four raw push-buttons into clean single-cycle move_left / move_right / move_down / rotate pulses, and generates the periodic gravity tick. Inputs are synchronised, debounced, edge-detected and auto-repeated. Outputs are arbitrated so at most one pulse is asserted per cycle; losing requests are held pending, not dropped. Sits between the board buttons and the controller's move/tick inputs.

---
 rtl/tetris_pkg.sv | 36 +++
 rtl/tetris_input_gen_if.sv | 28 ++
 rtl/tetris_btn_cond.sv | 110 +++++++++++
 rtl/tetris_input_gen.sv | 89 ++++++++
 tb/tb_tetris_input_gen.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris input generator and its piece controller.
//   - command vector width and priority indices (lower index wins arbitration)
//   - default timing constants for a 50 MHz system clock
//   - tick_period(): gravity period for a given level, clamped at a floor
package tetris_pkg;

    localparam int CMD_W       = 5;
    localparam int PRIO_LEFT   = 0;
    localparam int PRIO_RIGHT  = 1;
    localparam int PRIO_ROTATE = 2;
    localparam int PRIO_DOWN   = 3;
    localparam int PRIO_TICK   = 4;

    typedef logic [CMD_W-1:0] cmd_vec_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_REPEAT_DELAY    = 10000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;
    localparam int unsigned DEF_TICK_BASE       = 50000000;
    localparam int unsigned DEF_TICK_STEP       = 3000000;
    localparam int unsigned DEF_TICK_MIN        = 5000000;

    // Unsigned 32-bit arithmetic; the clamp is tested before subtracting so
    // the result never wraps.
    function automatic logic [31:0] tick_period(input logic [3:0]  level,
                                                input logic [31:0] base,
                                                input logic [31:0] step,
                                                input logic [31:0] tmin);
        logic [31:0] red;
        red = 32'(level) * step;
        if (tmin >= base || red >= base - tmin)
            return tmin;
        return base - red;
    endfunction

endpackage

// File: rtl/tetris_input_gen_if.sv
// Button/command bundle of the tetris input generator.
//   slave  : the generator (buttons, pause, level in; command pulses out)
//   master : the board / game side driving buttons and consuming commands
interface tetris_input_gen_if;

    logic       btn_left;
    logic       btn_right;
    logic       btn_down;
    logic       btn_rotate;
    logic       pause;
    logic [3:0] level;
    logic       move_left;
    logic       move_right;
    logic       move_down;
    logic       rotate;
    logic       tick;

    modport slave (
        input  btn_left, btn_right, btn_down, btn_rotate, pause, level,
        output move_left, move_right, move_down, rotate, tick
    );

    modport master (
        output btn_left, btn_right, btn_down, btn_rotate, pause, level,
        input  move_left, move_right, move_down, rotate, tick
    );

endinterface

// File: rtl/tetris_btn_cond.sv
// Conditioning for one raw push-button: 2-FF synchroniser, debounce,
// rising-edge request and optional auto-repeat.
// Auto-repeat is only built when TETRIS_INPUT_AUTOREPEAT_EN is defined and
// REPEAT_ON is set; otherwise each press gives exactly one request.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   btn_i      : raw asynchronous button, active-high
//   hold_i     : pause; discards requests and freezes the repeat timer
//   req_o      : single-cycle request (press or repeat)
module tetris_btn_cond
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit          REPEAT_ON       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    input  logic hold_i,
    output logic req_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Keeps the repeat parameters referenced when the repeat timer is compiled out.
    localparam int unsigned repeat_cfg_unused = int'(REPEAT_ON) + REPEAT_DELAY + REPEAT_PERIOD;

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            rise;
    logic            rpt_fire;

    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1))
                deb_d = ~deb_q;
            else
                db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign rise = deb_q & ~deb_prev_q;

`ifdef TETRIS_INPUT_AUTOREPEAT_EN
    generate
        if (REPEAT_ON) begin : g_rpt
            localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RPT_W = $clog2(RPT_MAX + 1);

            logic [RPT_W-1:0] rpt_q, rpt_d;
            logic             fire;

            // Down-counter to the next repeat. The press loads it even while
            // paused so a press made during pause starts a full delay.
            always_comb begin
                rpt_d = rpt_q;
                fire  = 1'b0;
                if (!deb_q) begin
                    rpt_d = '0;
                end else if (rise) begin
                    rpt_d = RPT_W'(REPEAT_DELAY - 1);
                end else if (!hold_i) begin
                    if (rpt_q == '0) begin
                        fire  = 1'b1;
                        rpt_d = RPT_W'(REPEAT_PERIOD - 1);
                    end else begin
                        rpt_d = rpt_q - RPT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset)
                    rpt_q <= '0;
                else
                    rpt_q <= rpt_d;
            end

            assign rpt_fire = fire;
        end else begin : g_no_rpt
            assign rpt_fire = 1'b0;
        end
    endgenerate
`else
    assign rpt_fire = 1'b0;
`endif

    assign req_o = (rise | rpt_fire) & ~hold_i;

endmodule

// File: rtl/tetris_input_gen.sv
// Command source for the tetris piece controller: four conditioned buttons
// plus the gravity tick, arbitrated into one-hot single-cycle pulses.
// Priority left > right > rotate > down > tick; losing requests stay pending.
// Optional auto-repeat on left/right/down: TETRIS_INPUT_AUTOREPEAT_EN.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : tetris_input_gen_if.slave (buttons, pause, level in;
//                move_left/move_right/move_down/rotate/tick out)
module tetris_input_gen
    import tetris_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned TICK_BASE       = DEF_TICK_BASE,
    parameter int unsigned TICK_STEP       = DEF_TICK_STEP,
    parameter int unsigned TICK_MIN        = DEF_TICK_MIN
) (
    input  logic              clk,
    input  logic              reset,
    tetris_input_gen_if.slave bus
);

    logic [3:0]  btn_req;
    logic [31:0] tick_cnt_q, tick_cnt_d, period;
    logic        tick_req;
    cmd_vec_t    pend_q, pend_d, cmd_q, grant, req_vec;

    tetris_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ON(1'b1)) u_left (
        .clk(clk), .reset(reset), .btn_i(bus.btn_left), .hold_i(bus.pause),
        .req_o(btn_req[PRIO_LEFT]));

    tetris_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ON(1'b1)) u_right (
        .clk(clk), .reset(reset), .btn_i(bus.btn_right), .hold_i(bus.pause),
        .req_o(btn_req[PRIO_RIGHT]));

    tetris_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ON(1'b0)) u_rotate (
        .clk(clk), .reset(reset), .btn_i(bus.btn_rotate), .hold_i(bus.pause),
        .req_o(btn_req[PRIO_ROTATE]));

    tetris_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_ON(1'b1)) u_down (
        .clk(clk), .reset(reset), .btn_i(bus.btn_down), .hold_i(bus.pause),
        .req_o(btn_req[PRIO_DOWN]));

    // Period follows level combinationally, so a level change that leaves the
    // counter past the new terminal count fires on the next edge.
    always_comb begin
        period     = tick_period(bus.level, TICK_BASE, TICK_STEP, TICK_MIN);
        tick_req   = !bus.pause && (tick_cnt_q >= period - 32'd1);
        tick_cnt_d = tick_cnt_q;
        if (!bus.pause)
            tick_cnt_d = tick_req ? '0 : tick_cnt_q + 32'd1;
    end

    always_comb begin
        req_vec            = '0;
        req_vec[3:0]       = btn_req;
        req_vec[PRIO_TICK] = tick_req;
        // Lowest set bit of the pending vector is the highest priority.
        grant  = bus.pause ? '0 : (pend_q & (~pend_q + cmd_vec_t'(1)));
        pend_d = (pend_q & ~grant) | req_vec;
        // Pause drops pending moves; all move indices sit below the tick.
        if (bus.pause)
            pend_d[PRIO_TICK-1:0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            pend_q     <= '0;
            cmd_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pend_q     <= pend_d;
            cmd_q      <= grant;
        end
    end

    assign bus.move_left  = cmd_q[PRIO_LEFT];
    assign bus.move_right = cmd_q[PRIO_RIGHT];
    assign bus.rotate     = cmd_q[PRIO_ROTATE];
    assign bus.move_down  = cmd_q[PRIO_DOWN];
    assign bus.tick       = cmd_q[PRIO_TICK];

endmodule

// File: tb/tb_tetris_input_gen.sv
// Testbench for tetris_input_gen: directed scenarios with fixed expected
// pulse times, then randomized stimulus, all compared every cycle against a
// behavioural model of the button/tick/arbitration rules.
module tb_tetris_input_gen;
    import tetris_pkg::*;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;
    localparam int unsigned TBASE = 100;
    localparam int unsigned TSTEP = 10;
    localparam int unsigned TMIN = 30;
`ifdef TETRIS_INPUT_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tetris_input_gen_if bus();

    tetris_input_gen #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
        .TICK_BASE(TBASE), .TICK_STEP(TSTEP), .TICK_MIN(TMIN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int q_left[$], q_right[$], q_rot[$], q_down[$], q_tick[$];
    logic [4:0] last_obs;

    // Behavioural model state
    bit   m_r1[4], m_r2[4], m_deb[4], m_rose[4], m_active[4];
    int   m_run[4], m_age[4], m_target[4];
    int   m_tcnt;
    logic [4:0] m_pend, m_out;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_period(input int lvl);
        int p;
        p = int'(TBASE) - lvl * int'(TSTEP);
        return (p < int'(TMIN)) ? int'(TMIN) : p;
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // One rising edge of the model, using the inputs the DUT samples there.
    function automatic void model_step();
        logic [3:0] raw;
        logic [4:0] req;
        bit         p;
        bit         nr;
        int         per;
        raw = {bus.btn_down, bus.btn_rotate, bus.btn_right, bus.btn_left};
        p   = bus.pause;
        req = '0;
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                m_r1[b] = 0; m_r2[b] = 0; m_deb[b] = 0; m_rose[b] = 0;
                m_active[b] = 0; m_run[b] = 0; m_age[b] = 0; m_target[b] = 0;
            end
            m_tcnt = 0; m_pend = '0; m_out = '0;
            return;
        end
        for (int b = 0; b < 4; b++) begin
            // press request one cycle after debounced rise; repeats after
            // RD then every RP unpaused cycles while still held
            if (m_rose[b]) begin
                if (!p) req[b] = 1'b1;
                m_active[b] = 1; m_age[b] = 0; m_target[b] = RD;
            end else if (m_deb[b] && m_active[b] && RPT_EN && b != PRIO_ROTATE && !p) begin
                m_age[b]++;
                if (m_age[b] == m_target[b]) begin
                    req[b] = 1'b1; m_age[b] = 0; m_target[b] = RP;
                end
            end
            if (!m_deb[b]) m_active[b] = 0;
            nr = 0;
            if (m_r2[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == int'(DB)) begin
                    m_deb[b] = ~m_deb[b]; m_run[b] = 0; nr = m_deb[b];
                end
            end else begin
                m_run[b] = 0;
            end
            m_rose[b] = nr;
            m_r2[b] = m_r1[b];
            m_r1[b] = raw[b];
        end
        per = ref_period(int'(bus.level));
        if (!p) begin
            if (m_tcnt >= per - 1) begin
                req[PRIO_TICK] = 1'b1; m_tcnt = 0;
            end else begin
                m_tcnt++;
            end
        end
        m_out = '0;
        if (!p) begin
            for (int i = 0; i < 5; i++) begin
                if (m_pend[i]) begin
                    m_out[i] = 1'b1;
                    break;
                end
            end
        end
        m_pend = (m_pend & ~m_out) | req;
        if (p) m_pend = m_pend & 5'b10000;
    endfunction

    task automatic step();
        logic [4:0] obs;
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        obs = {bus.tick, bus.move_down, bus.rotate, bus.move_right, bus.move_left};
        last_obs = obs;
        check("outs_vs_model", int'(obs), int'(m_out));
        check("one_hot", int'($countones(obs) <= 1), 1);
        if (obs[PRIO_LEFT])   q_left.push_back(cyc);
        if (obs[PRIO_RIGHT])  q_right.push_back(cyc);
        if (obs[PRIO_ROTATE]) q_rot.push_back(cyc);
        if (obs[PRIO_DOWN])   q_down.push_back(cyc);
        if (obs[PRIO_TICK])   q_tick.push_back(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int lvl);
        reset = 1'b1;
        bus.btn_left = 0; bus.btn_right = 0; bus.btn_down = 0; bus.btn_rotate = 0;
        bus.pause = 0; bus.level = 4'(lvl);
        run(3);
        check("reset_outs", int'(last_obs), 0);
        reset = 1'b0;
        t0 = cyc + 1;
        q_left.delete(); q_right.delete(); q_rot.delete(); q_down.delete(); q_tick.delete();
    endtask

    initial begin
        int t;
        int exp_down[$];

        // 1: idle gravity at level 0
        do_reset(0);
        run(305);
        check("s1_tick_cnt", q_tick.size(), 3);
        check("s1_tick0", qat(q_tick, 0), t0 + 100);
        check("s1_tick1", qat(q_tick, 1), t0 + 200);
        check("s1_tick2", qat(q_tick, 2), t0 + 300);
        check("s1_moves", q_left.size() + q_right.size() + q_rot.size() + q_down.size(), 0);

        // 2: short glitches ignored, then a clean press
        do_reset(0);
        repeat (5) begin
            bus.btn_left = 1; run(2);
            bus.btn_left = 0; run(4);
        end
        check("s2_glitch", q_left.size(), 0);
        t = cyc + 1;
        bus.btn_left = 1; run(15);
        bus.btn_left = 0; run(20);
        check("s2_left_cnt", q_left.size(), 1);
        check("s2_left_lat", qat(q_left, 0), t + 7);

        // 3: held down button with auto-repeat
        do_reset(0);
        t = cyc + 1;
        bus.btn_down = 1; run(60);
        bus.btn_down = 0; run(20);
        if (RPT_EN) exp_down = '{7, 27, 35, 43, 51, 59};
        else        exp_down = '{7};
        check("s3_down_cnt", q_down.size(), exp_down.size());
        for (int i = 0; i < exp_down.size(); i++)
            check($sformatf("s3_down%0d", i), qat(q_down, i), t + exp_down[i]);

        // 4: left, rotate and tick contend on the same cycle
        do_reset(0);
        run(93);
        bus.btn_left = 1; bus.btn_rotate = 1; run(10);
        bus.btn_left = 0; bus.btn_rotate = 0; run(20);
        check("s4_left", qat(q_left, 0), t0 + 100);
        check("s4_rotate", qat(q_rot, 0), t0 + 101);
        check("s4_tick", qat(q_tick, 0), t0 + 102);

        // 5: level-dependent period, clamp, and a level change mid-count
        do_reset(9);
        run(95);
        check("s5_l9_t0", qat(q_tick, 0), t0 + 30);
        check("s5_l9_per", qat(q_tick, 1) - qat(q_tick, 0), 30);
        do_reset(5);
        run(105);
        check("s5_l5_t0", qat(q_tick, 0), t0 + 50);
        check("s5_l5_per", qat(q_tick, 1) - qat(q_tick, 0), 50);
        do_reset(2);
        run(60);
        bus.level = 4'd5;
        run(61);
        check("s5_switch_t0", qat(q_tick, 0), t0 + 61);
        check("s5_switch_t1", qat(q_tick, 1), t0 + 111);

        // 6: pause freezes the tick counter and discards a press
        do_reset(0);
        run(60);
        bus.pause = 1; run(100);
        bus.btn_right = 1; run(30);
        bus.btn_right = 0; run(370);
        bus.pause = 0; run(60);
        check("s6_tick_cnt", q_tick.size(), 1);
        check("s6_tick", qat(q_tick, 0), t0 + 600);
        check("s6_right", q_right.size(), 0);

        // random stimulus against the model
        do_reset(3);
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) bus.btn_left   = ~bus.btn_left;
            if ($urandom_range(0, 15) == 0) bus.btn_right  = ~bus.btn_right;
            if ($urandom_range(0, 15) == 0) bus.btn_down   = ~bus.btn_down;
            if ($urandom_range(0, 15) == 0) bus.btn_rotate = ~bus.btn_rotate;
            if ($urandom_range(0, 39) == 0) bus.pause      = ~bus.pause;
            if ($urandom_range(0, 59) == 0) bus.level      = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
